// File: rtl/fir_axis_serial_mac_if.sv
// AXI-Stream link used on both sides of fir_axis_serial_mac.
// W is the tdata width; tkeep carries one bit per tdata byte.
interface fir_axis_serial_mac_if #(
  parameter int W = 32
) ();
  logic signed [W-1:0]   tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [W/8-1:0]        tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/fir_axis_serial_mac.sv
// Serial-MAC AXI-Stream FIR filter: one shared multiplier, one tap per clock.
// A sample is accepted in IDLE, TAPS MAC cycles follow, then the result is
// held in OUT until the consumer takes it (one sample per TAPS+2 clocks).
// Coefficients are writable at run time while IDLE.
// Optional build macro FIR_SATURATE_EN: saturate the accumulator to OUT_W
// instead of the default two's-complement wrap.
module fir_axis_serial_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 32,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  fir_axis_serial_mac_if.slave     s_axis_fir,
  fir_axis_serial_mac_if.master    m_axis_fir,
  input  logic                     coef_wr_en,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_err,
  output logic                     busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int EXT_W  = (OUT_W > ACC_W) ? OUT_W : ACC_W;
  localparam logic [AW:0]   TAPS_L = (AW+1)'(TAPS);
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_p0 [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic                     tlast_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic [AW-1:0]            k_p1;
  logic signed [OUT_W-1:0]  tdata_p2;
  logic                     tlast_p2;
  logic                     coef_err_q;

  logic                     accept;
  logic                     mac_last;
  logic                     coef_ok;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;

  // Reduce the full-precision accumulator to the output width.
  function automatic logic signed [OUT_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] e;
`ifdef FIR_SATURATE_EN
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    e  = EXT_W'(a);
    hi = EXT_W'(signed'({1'b0, {(OUT_W-1){1'b1}}}));
    lo = EXT_W'(signed'({1'b1, {(OUT_W-1){1'b0}}}));
    if (e > hi)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (e < lo) return {1'b1, {(OUT_W-1){1'b0}}};
    else             return e[OUT_W-1:0];
`else
    e = EXT_W'(a);
    return e[OUT_W-1:0];
`endif
  endfunction

  assign accept   = (state_q == IDLE) && s_axis_fir.tvalid;
  assign mac_last = (k_p1 == K_LAST);
  assign coef_ok  = coef_wr_en && (state_q == IDLE) && ({1'b0, coef_addr} < TAPS_L);
  assign prod     = coef_q[k_p1] * x_p0[k_p1];
  assign acc_sum  = acc_p1 + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

  // Next-state decode for the IDLE -> MAC -> OUT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_axis_fir.tvalid) state_d = MAC;
      MAC:     if (mac_last)          state_d = OUT;
      OUT:     if (m_axis_fir.tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // p0: sample capture into the delay line; p1: tap-serial MAC; p2: output hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x_p0[i] <= '0;
      tlast_p0 <= 1'b0;
      acc_p1   <= '0;
      k_p1     <= '0;
      tdata_p2 <= '0;
      tlast_p2 <= 1'b0;
    end else if (accept) begin
      x_p0[0] <= s_axis_fir.tdata;
      for (int i = 1; i < TAPS; i++) x_p0[i] <= x_p0[i-1];
      tlast_p0 <= s_axis_fir.tlast;
      acc_p1   <= '0;
      k_p1     <= '0;
    end else if (state_q == MAC) begin
      acc_p1 <= acc_sum;
      k_p1   <= k_p1 + 1'b1;
      if (mac_last) begin
        tdata_p2 <= reduce_acc(acc_sum);
        tlast_p2 <= tlast_p0;
      end
    end
  end

  // Coefficient bank writes and the one-cycle rejection pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
      coef_err_q <= 1'b0;
    end else begin
      if (coef_ok) coef_q[coef_addr] <= coef_wdata;
      coef_err_q <= coef_wr_en && !coef_ok;
    end
  end

  assign s_axis_fir.tready = (state_q == IDLE) && !reset;
  assign m_axis_fir.tvalid = (state_q == OUT);
  assign m_axis_fir.tdata  = tdata_p2;
  assign m_axis_fir.tlast  = tlast_p2;
  assign m_axis_fir.tkeep  = '1;
  assign coef_err          = coef_err_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_fir_axis_serial_mac.sv
// Directed bench for fir_axis_serial_mac (TAPS=8) plus a TAPS=5 instance
// used for the out-of-range coefficient address case.
module tb_fir_axis_serial_mac;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_axis_serial_mac_if #(.W(16)) s_if ();
  fir_axis_serial_mac_if #(.W(32)) m_if ();
  fir_axis_serial_mac_if #(.W(16)) s5_if ();
  fir_axis_serial_mac_if #(.W(32)) m5_if ();

  logic               coef_wr_en, coef_wr_en5;
  logic [2:0]         coef_addr, coef_addr5;
  logic signed [15:0] coef_wdata, coef_wdata5;
  logic               coef_err, coef_err5;
  logic               busy, busy5;

  int n_cmp  = 0;
  int n_fail = 0;

  fir_axis_serial_mac #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(32)) dut (
    .clk(clk), .reset(reset), .s_axis_fir(s_if.slave), .m_axis_fir(m_if.master),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .busy(busy));

  fir_axis_serial_mac #(.DATA_W(16), .COEF_W(16), .TAPS(5), .OUT_W(32)) dut5 (
    .clk(clk), .reset(reset), .s_axis_fir(s5_if.slave), .m_axis_fir(m5_if.master),
    .coef_wr_en(coef_wr_en5), .coef_addr(coef_addr5), .coef_wdata(coef_wdata5),
    .coef_err(coef_err5), .busy(busy5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    coef_wr_en = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    s_if.tdata = d; s_if.tvalid = 1'b1; s_if.tlast = l;
    while (!s_if.tready && n < 200) begin @(negedge clk); n++; end
    check("send_ready", s_if.tready, 1);
    @(negedge clk);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_if.tvalid && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic expect_out(input logic [31:0] d, input logic l, input string tag);
    wait_valid();
    check({tag, "_vld"}, m_if.tvalid, 1);
    check({tag, "_data"}, m_if.tdata, d);
    check({tag, "_last"}, m_if.tlast, l);
    m_if.tready = 1'b1;
    @(negedge clk);
    m_if.tready = 1'b0;
  endtask

  initial begin
    int first;
    bit rdy_low;
    bit stable;
    logic [31:0] d0;
    logic l0;

    reset = 1'b1;
    s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tkeep = '1;
    m_if.tready = 1'b0;
    s5_if.tdata = '0; s5_if.tvalid = 1'b0; s5_if.tlast = 1'b0; s5_if.tkeep = '1;
    m5_if.tready = 1'b0;
    coef_wr_en = 1'b0; coef_addr = '0; coef_wdata = '0;
    coef_wr_en5 = 1'b0; coef_addr5 = '0; coef_wdata5 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", s_if.tready, 1);
    check("tkeep", m_if.tkeep, 32'hF);
    @(negedge clk);

    // Impulse response with c[k] = k+1, including latency and handshake
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'(i + 1));
    check("coef_load_err", coef_err, 0);
    send(16'd1, 1'b0);
    check("busy_mac", busy, 1);
    first = 0; rdy_low = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (s_if.tready) rdy_low = 1'b0;
      if (m_if.tvalid) begin first = n; break; end
      @(negedge clk);
    end
    check("latency", first, 9);
    check("s_tready_low", rdy_low, 1);
    expect_out(32'd1, 1'b0, "imp0");
    for (int i = 1; i < 9; i++)
      expect_out_after_send(i);

    // Backpressure: 100 stalled cycles with the next sample already offered
    send(16'd10, 1'b0);
    wait_valid();
    d0 = m_if.tdata; l0 = m_if.tlast;
    s_if.tdata = 16'd20; s_if.tvalid = 1'b1; s_if.tlast = 1'b0;
    stable = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_if.tdata !== d0 || m_if.tlast !== l0 || s_if.tready !== 1'b0 || m_if.tvalid !== 1'b1)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    expect_out(32'd10, 1'b0, "bp0");
    send(16'd20, 1'b0);
    expect_out(32'd40, 1'b0, "bp1");
    send(16'd30, 1'b1);
    expect_out(32'd100, 1'b1, "bp2");
    send(16'd0, 1'b0);
    expect_out(32'd160, 1'b0, "bp3");

    // Coefficient write during MAC is rejected
    send(16'd3, 1'b0);
    coef_wr_en = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h0100;
    @(negedge clk);
    coef_wr_en = 1'b0;
    check("err_pulse", coef_err, 1);
    @(negedge clk);
    check("err_clear", coef_err, 0);
    expect_out(32'd223, 1'b0, "cerr0");
    send(16'd5, 1'b0);
    expect_out(32'd291, 1'b0, "cerr1");

    // Out-of-range address on the TAPS=5 instance, then a legal one
    coef_wr_en5 = 1'b1; coef_addr5 = 3'd7; coef_wdata5 = 16'd1;
    @(negedge clk);
    coef_wr_en5 = 1'b0;
    check("addr_range_err", coef_err5, 1);
    coef_wr_en5 = 1'b1; coef_addr5 = 3'd4;
    @(negedge clk);
    coef_wr_en5 = 1'b0;
    check("addr_ok_err", coef_err5, 0);

    // Overflow: all coefficients 0x7FFF, eight samples of 0x8000
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'h7FFF);
    for (int i = 0; i < 7; i++) begin
      send(16'h8000, 1'b0);
      wait_valid();
      m_if.tready = 1'b1;
      @(negedge clk);
      m_if.tready = 1'b0;
    end
    send(16'h8000, 1'b0);
`ifdef FIR_SATURATE_EN
    expect_out(32'h8000_0000, 1'b0, "ovf7");
`else
    expect_out(32'h0004_0000, 1'b0, "ovf7");
`endif

    // Reset in the middle of MAC, then a clean impulse
    send(16'h1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_s_tready", s_if.tready, 0);
    check("mid_rst_m_tvalid", m_if.tvalid, 0);
    check("mid_rst_m_tdata", m_if.tdata, 0);
    check("mid_rst_m_tlast", m_if.tlast, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_coef_err", coef_err, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", s_if.tready, 1);
    @(negedge clk);
    for (int i = 1; i < 8; i++) write_coef(3'(i), 16'(i + 1));
    coef_wr_en = 1'b1; coef_addr = 3'd0; coef_wdata = 16'd1;
    send(16'd1, 1'b0);
    coef_wr_en = 1'b0;
    check("wr_accept_err", coef_err, 0);
    expect_out(32'd1, 1'b0, "rimp0");
    send(16'd0, 1'b0);
    expect_out(32'd2, 1'b0, "rimp1");
    send(16'd0, 1'b0);
    expect_out(32'd3, 1'b0, "rimp2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  task automatic expect_out_after_send(input int i);
    send(16'd0, 1'b0);
    expect_out((i < 8) ? 32'(i + 1) : 32'd0, 1'b0, $sformatf("imp%0d", i));
  endtask

endmodule
